// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_pkg
// Description : Shared types and helpers for the multi-direction traffic
//               light controller (state encoding, dir-index width).
// Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    // Width of the approach index; never narrower than one bit.
    function automatic int dir_w(input int num_dir);
        return (num_dir <= 2) ? 1 : $clog2(num_dir);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : tl_phase_timer
// Description : Loadable down-counter for phase durations. Advances only on
//               enabled clocks, flags zero, and reports how many enabled
//               clocks have elapsed since the last load.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_phase_timer
    import tl_pkg::*;
#(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] elapsed,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load on phase entry, otherwise count down toward zero while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= RST_VAL;
            elapsed <= '0;
        end else if (en) begin
            if (load) begin
                count   <= load_val;
                elapsed <= '0;
            end else if (count != '0) begin
                count   <= count - 1'b1;
                elapsed <= elapsed + 1'b1;
            end
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/tl_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tl_multi_ctrl
// Description : Multi-approach traffic-light controller. Cycles NUM_DIR
//               approaches through GREEN -> YELLOW -> ALLRED with per-phase
//               durations counted in en-qualified clocks. All lamp outputs
//               are registered Moore outputs.
//               Optional feature macro TL_PED_EN: pedestrian request
//               latching, walk lamps, request acknowledge and green
//               truncation. Without it ped_req is ignored and walk/ped_ack
//               stay low.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_multi_ctrl
    import tl_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int CNT_W      = 8,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int MIN_GREEN  = 6
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      en,
    input  logic [NUM_DIR-1:0]        ped_req,
    output logic [NUM_DIR-1:0]        green,
    output logic [NUM_DIR-1:0]        yellow,
    output logic [NUM_DIR-1:0]        red,
    output logic [NUM_DIR-1:0]        walk,
    output logic [NUM_DIR-1:0]        ped_ack,
    output logic [dir_w(NUM_DIR)-1:0] dir,
    output logic                      phase_done
);

    localparam int               DIR_W        = dir_w(NUM_DIR);
    localparam logic [CNT_W-1:0] GREEN_LD     = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD    = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD    = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_GREEN_M1 = CNT_W'(MIN_GREEN - 1);
    localparam logic [DIR_W-1:0] DIR_LAST     = DIR_W'(NUM_DIR - 1);

    // Elaboration-time parameter range checks.
    generate
        if (NUM_DIR < 2 || NUM_DIR > 4) begin : g_chk_num_dir
            $error("tl_multi_ctrl: NUM_DIR must be in 2..4");
        end
        if (GREEN_CYC < 1 || GREEN_CYC > (1 << CNT_W)) begin : g_chk_green
            $error("tl_multi_ctrl: GREEN_CYC out of range");
        end
        if (YELLOW_CYC < 1 || YELLOW_CYC > (1 << CNT_W)) begin : g_chk_yellow
            $error("tl_multi_ctrl: YELLOW_CYC out of range");
        end
        if (ALLRED_CYC < 1 || ALLRED_CYC > (1 << CNT_W)) begin : g_chk_allred
            $error("tl_multi_ctrl: ALLRED_CYC out of range");
        end
        if (MIN_GREEN < 1 || MIN_GREEN > GREEN_CYC) begin : g_chk_min_green
            $error("tl_multi_ctrl: MIN_GREEN out of range");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic [DIR_W-1:0]   dir_nxt;
    logic               go;
    logic [CNT_W-1:0]   load_val;
    logic [CNT_W-1:0]   elapsed;
    logic               zero;
    logic               trunc;
    logic [NUM_DIR-1:0] cur_oh;
    logic [NUM_DIR-1:0] nxt_oh;
    logic [NUM_DIR-1:0] pending;
    logic [NUM_DIR-1:0] pending_nxt;
    logic [NUM_DIR-1:0] ack_nxt;
    logic [NUM_DIR-1:0] walk_nxt;
    logic [NUM_DIR-1:0] green_nxt;
    logic [NUM_DIR-1:0] yellow_nxt;
    logic               phase_done_nxt;

    tl_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_LD)
    ) u_timer (
        .clk      (clk),
        .rst_n    (res),
        .en       (en),
        .load     (go),
        .load_val (load_val),
        .elapsed  (elapsed),
        .zero     (zero)
    );

    assign cur_oh = NUM_DIR'(1) << dir;
    assign nxt_oh = NUM_DIR'(1) << dir_nxt;

`ifdef TL_PED_EN
    logic enter_green;

    // Another approach waiting, and this green has run long enough.
    assign trunc       = (|(pending & ~cur_oh)) && (elapsed >= MIN_GREEN_M1);
    assign enter_green = go && (state == ALLRED);
    // A request already latched, or arriving on the entry clock, is granted.
    assign ack_nxt     = enter_green ? (nxt_oh & (pending | ped_req)) : '0;
    assign walk_nxt    = enter_green ? ack_nxt
                                     : ((state_nxt == GREEN) ? walk : '0);
    // The grant wins over a simultaneous re-request of the same approach.
    assign pending_nxt = (pending | ped_req) & ~ack_nxt;
`else
    logic unused_ped;

    assign trunc       = 1'b0;
    assign ack_nxt     = '0;
    assign walk_nxt    = '0;
    assign pending_nxt = '0;
    assign unused_ped  = ^{ped_req, elapsed, pending};
`endif

    // Next-state, next-dir and timer reload value.
    always_comb begin
        go        = 1'b0;
        state_nxt = state;
        dir_nxt   = dir;
        load_val  = ALLRED_LD;
        case (state)
            ALLRED:  go = zero;
            GREEN:   go = zero | trunc;
            YELLOW:  go = zero;
            default: go = 1'b1;
        endcase
        go = go & en;
        if (go) begin
            case (state)
                ALLRED: state_nxt = GREEN;
                GREEN:  state_nxt = YELLOW;
                default: begin
                    state_nxt = ALLRED;
                    dir_nxt   = (dir == DIR_LAST) ? '0 : dir + 1'b1;
                end
            endcase
        end
        case (state_nxt)
            GREEN:   load_val = GREEN_LD;
            YELLOW:  load_val = YELLOW_LD;
            default: load_val = ALLRED_LD;
        endcase
    end

    // Lamp values that go with the next state.
    always_comb begin
        green_nxt      = '0;
        yellow_nxt     = '0;
        phase_done_nxt = go && (state == YELLOW);
        if (state_nxt == GREEN) begin
            green_nxt = nxt_oh;
        end
        if (state_nxt == YELLOW) begin
            yellow_nxt = nxt_oh;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= ALLRED;
            dir   <= '0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
        end
    end

    // Registered outputs, updated on the same edge as the state register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            green      <= '0;
            yellow     <= '0;
            red        <= '1;
            walk       <= '0;
            ped_ack    <= '0;
            phase_done <= 1'b0;
            pending    <= '0;
        end else begin
            green      <= green_nxt;
            yellow     <= yellow_nxt;
            red        <= ~(green_nxt | yellow_nxt);
            walk       <= walk_nxt;
            ped_ack    <= ack_nxt;
            phase_done <= phase_done_nxt;
            pending    <= pending_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tl_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_multi_ctrl
// Description : Scoreboard bench for tl_multi_ctrl. Two instances: NUM_DIR=2
//               (main scenarios) and NUM_DIR=3 (wrap). Stimulus pushes the
//               expected per-cycle lamp vector; monitors pop and compare on
//               the falling edge. Pedestrian scenarios follow TL_PED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_multi_ctrl;

    localparam int AR = 0;
    localparam int GR = 1;
    localparam int YL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res2, en2;
    logic [1:0] ped2, g2, y2, r2, w2, a2;
    logic [0:0] d2;
    logic       pd2;

    logic       res3, en3;
    logic [2:0] ped3, g3, y3, r3, w3, a3;
    logic [1:0] d3;
    logic       pd3;

    tl_multi_ctrl #(
        .NUM_DIR(2), .CNT_W(8), .GREEN_CYC(5), .YELLOW_CYC(2),
        .ALLRED_CYC(1), .MIN_GREEN(2)
    ) u2 (
        .clk(clk), .res(res2), .en(en2), .ped_req(ped2),
        .green(g2), .yellow(y2), .red(r2), .walk(w2), .ped_ack(a2),
        .dir(d2), .phase_done(pd2)
    );

    tl_multi_ctrl #(
        .NUM_DIR(3), .CNT_W(8), .GREEN_CYC(5), .YELLOW_CYC(2),
        .ALLRED_CYC(1), .MIN_GREEN(2)
    ) u3 (
        .clk(clk), .res(res3), .en(en3), .ped_req(ped3),
        .green(g3), .yellow(y3), .red(r3), .walk(w3), .ped_ack(a3),
        .dir(d3), .phase_done(pd3)
    );

    typedef struct {
        string      nm;
        logic [2:0] g, y, r, w, a;
        logic [1:0] d;
        logic       pd;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done3    = 1'b0;

    task automatic check(input exp_t e, input logic [2:0] g, input logic [2:0] y,
                         input logic [2:0] r, input logic [2:0] w, input logic [2:0] a,
                         input logic [1:0] d, input logic pd);
        n_checks++;
        if ({g, y, r, w, a, d, pd} !== {e.g, e.y, e.r, e.w, e.a, e.d, e.pd}) begin
            n_fail++;
            $display("FAIL %s @%0t: got g=%b y=%b r=%b walk=%b ack=%b dir=%0d pd=%b, expected g=%b y=%b r=%b walk=%b ack=%b dir=%0d pd=%b",
                     e.nm, $time, g, y, r, w, a, d, pd,
                     e.g, e.y, e.r, e.w, e.a, e.d, e.pd);
        end
    endtask

    // Monitor for the two-approach instance.
    always @(negedge clk) begin
        if (q2.size() > 0) begin
            check(q2.pop_front(), {1'b0, g2}, {1'b0, y2}, {1'b0, r2},
                  {1'b0, w2}, {1'b0, a2}, {1'b0, d2}, pd2);
        end
    end

    // Monitor for the three-approach instance.
    always @(negedge clk) begin
        if (q3.size() > 0) begin
            check(q3.pop_front(), g3, y3, r3, w3, a3, d3, pd3);
        end
    end

    // Wait for the next cycle and push its expected outputs. kind selects
    // the lamp (AR/GR/YL) for approach d; w/a set walk/ack for d.
    task automatic cyc(input int which, input string nm, input int kind, input int d,
                       input logic w, input logic a, input logic pd);
        exp_t       e;
        logic [2:0] oh;
        logic [2:0] mask;
        mask = (which == 3) ? 3'b111 : 3'b011;
        oh   = 3'b001 << d;
        @(posedge clk);
        #1;
        e.nm = nm;
        e.g  = (kind == GR) ? oh : 3'b000;
        e.y  = (kind == YL) ? oh : 3'b000;
        e.r  = ~(e.g | e.y) & mask;
        e.w  = w ? oh : 3'b000;
        e.a  = a ? oh : 3'b000;
        e.d  = 2'(d);
        e.pd = pd;
        if (which == 3) q3.push_back(e);
        else            q2.push_back(e);
    endtask

    task automatic ph(input int which, input string nm, input int kind, input int d,
                      input int n, input logic w, input logic a_first, input logic pd_first);
        for (int i = 0; i < n; i++) begin
            cyc(which, nm, kind, d, w, a_first && (i == 0), pd_first && (i == 0));
        end
    endtask

    // Three-approach wrap sequence: greens for dir 0,1,2,0.
    initial begin
        res3 = 1'b0;
        en3  = 1'b1;
        ped3 = 3'b000;
        ph(3, "rst3", AR, 0, 2, 0, 0, 0);
        cyc(3, "rel3", AR, 0, 0, 0, 0);
        res3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ph(3, "g3", GR, k % 3, 5, 0, 0, 0);
            if (k < 3) begin
                ph(3, "y3", YL, k % 3, 2, 0, 0, 0);
                ph(3, "ar3", AR, (k + 1) % 3, 1, 0, 0, 1);
            end
        end
        done3 = 1'b1;
    end

    // Main two-approach scenarios, then drain and summary.
    initial begin
        res2 = 1'b0;
        en2  = 1'b1;
        ped2 = 2'b00;

        // Reset and free-run.
        ph(2, "reset", AR, 0, 3, 0, 0, 0);
        cyc(2, "release", AR, 0, 0, 0, 0);
        res2 = 1'b1;
        ph(2, "free_g0", GR, 0, 5, 0, 0, 0);
        ph(2, "free_y0", YL, 0, 2, 0, 0, 0);
        ph(2, "free_ar1", AR, 1, 1, 0, 0, 1);
        ph(2, "free_g1", GR, 1, 5, 0, 0, 0);
        ph(2, "free_y1", YL, 1, 2, 0, 0, 0);
        ph(2, "free_ar0", AR, 0, 1, 0, 0, 1);

        // en low for three clocks in the middle of green[0].
        ph(2, "en_g0", GR, 0, 3, 0, 0, 0);
        en2 = 1'b0;
        ph(2, "en_g0_frz", GR, 0, 2, 0, 0, 0);
        cyc(2, "en_g0", GR, 0, 0, 0, 0);
        en2 = 1'b1;
        ph(2, "en_g0", GR, 0, 2, 0, 0, 0);
        ph(2, "en_y0", YL, 0, 2, 0, 0, 0);
        ph(2, "en_ar1", AR, 1, 1, 0, 0, 1);
        ph(2, "en_g1", GR, 1, 5, 0, 0, 0);
        ph(2, "en_y1", YL, 1, 2, 0, 0, 0);
        ph(2, "en_ar0", AR, 0, 1, 0, 0, 1);

`ifdef TL_PED_EN
        // Request for approach 1 truncates green[0] after MIN_GREEN clocks.
        cyc(2, "trunc_g0", GR, 0, 0, 0, 0);
        ped2 = 2'b10;
        cyc(2, "trunc_g0", GR, 0, 0, 0, 0);
        ped2 = 2'b00;
        ph(2, "trunc_y0", YL, 0, 2, 0, 0, 0);
        ph(2, "trunc_ar1", AR, 1, 1, 0, 0, 1);
        // Granted green[1]: ack once, walk throughout; own request mid-green.
        cyc(2, "walk_g1", GR, 1, 1, 1, 0);
        cyc(2, "walk_g1", GR, 1, 1, 0, 0);
        ped2 = 2'b10;
        cyc(2, "walk_g1", GR, 1, 1, 0, 0);
        ped2 = 2'b00;
        ph(2, "walk_g1", GR, 1, 2, 1, 0, 0);
        ph(2, "walk_y1", YL, 1, 2, 0, 0, 0);
        // Request for 0 on the entry clock; pending[1] truncates green[0].
        cyc(2, "walk_ar0", AR, 0, 0, 0, 1);
        ped2 = 2'b01;
        cyc(2, "walk_g0", GR, 0, 1, 1, 0);
        ped2 = 2'b00;
        cyc(2, "walk_g0", GR, 0, 1, 0, 0);
        ph(2, "walk_y0", YL, 0, 2, 0, 0, 0);
        ph(2, "walk_ar1", AR, 1, 1, 0, 0, 1);
        ph(2, "late_g1", GR, 1, 5, 1, 1, 0);
        ph(2, "late_y1", YL, 1, 2, 0, 0, 0);
        ph(2, "late_ar0", AR, 0, 1, 0, 0, 1);
`else
        // Pedestrian path absent: requests change nothing.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
                cyc(2, "noped_g", GR, k, 0, 0, 0);
                ped2 = 2'($urandom_range(0, 3));
            end
            for (int i = 0; i < 2; i++) begin
                cyc(2, "noped_y", YL, k, 0, 0, 0);
                ped2 = 2'($urandom_range(0, 3));
            end
            cyc(2, "noped_ar", AR, 1 - k, 0, 0, 1);
            ped2 = 2'($urandom_range(0, 3));
        end
        ped2 = 2'b00;
`endif

        // Asynchronous reset between edges in the middle of yellow.
        ph(2, "pre_g0", GR, 0, 5, 0, 0, 0);
        cyc(2, "pre_y0", YL, 0, 0, 0, 0);
        cyc(2, "async_rst", AR, 0, 0, 0, 0);
        #1;
        res2 = 1'b0;
        cyc(2, "rst_hold", AR, 0, 0, 0, 0);
        cyc(2, "rst_rel", AR, 0, 0, 0, 0);
        res2 = 1'b1;
        ph(2, "post_g0", GR, 0, 5, 0, 0, 0);
        cyc(2, "post_y0", YL, 0, 0, 0, 0);

        for (int i = 0; i < 2000 && !done3; i++) @(posedge clk);
        if (!done3) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut3_done: got done=0, expected done=1");
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (q2.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got q2=%0d q3=%0d, expected 0 0", q2.size(), q3.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/tl_multi_ctrl.md
# tl_multi_ctrl

Parametrised multi-direction traffic-light controller: the next-generation replacement for the single-output light sequencer. Cycles NUM_DIR approaches through GREEN -> YELLOW -> ALL-RED phases, each with its own parametrised duration counted in `en`-qualified clocks. An optional pedestrian-request path can shorten green and grant walk phases. Sits directly under the intersection top level and drives the lamp-driver outputs.

## Interface
- NUM_DIR, 2: number of approaches, legal 2..4.
- CNT_W, 8: phase timer width.
- GREEN_CYC, 20: green duration in enabled cycles, 1..2^CNT_W.
- YELLOW_CYC, 4: yellow duration, 1..2^CNT_W.
- ALLRED_CYC, 2: all-red clearance duration, 1..2^CNT_W.
- MIN_GREEN, 6: minimum green before pedestrian truncation, 1..GREEN_CYC.
- clk  in  1  single clock, rising edge.
- res  in  1  reset; asynchronous, active-low.
- en  in  1  tick enable; timer and state advance only when high.
- ped_req  in  NUM_DIR  pedestrian request per approach, level.
- green  out  NUM_DIR  one-hot green lamp.
- yellow  out  NUM_DIR  one-hot yellow lamp.
- red  out  NUM_DIR  red lamp, high for every non-active approach.
- walk  out  NUM_DIR  walk lamp.
- ped_ack  out  NUM_DIR  one-cycle request acknowledge.
- dir  out  clog2(NUM_DIR)  active approach index.
- phase_done  out  1  one-cycle pulse on YELLOW -> ALLRED.

## Operation
- States: ALLRED, GREEN, YELLOW. Moore outputs, all registered.
- Reset values: state ALLRED, dir 0, timer ALLRED_CYC-1, red all ones, green/yellow/walk/ped_ack 0, phase_done 0, pending 0.
- On entering a state, timer loads duration-1. Transition occurs on a clock where en=1 and timer==0. Otherwise, when en=1, timer decrements.
- ALLRED -> GREEN keeps dir. GREEN -> YELLOW keeps dir. YELLOW -> ALLRED sets dir to dir+1, wrapping NUM_DIR-1 -> 0.
- red[i] = !(green[i] | yellow[i]). Exactly one approach is non-red in GREEN/YELLOW; none in ALLRED.
- en low freezes state and timer. ped_req is still latched.
- Any async reset assertion forces reset values immediately, including mid-phase.

## Timing
- With en held high, each approach cycle is GREEN_CYC + YELLOW_CYC + ALLRED_CYC clocks.
- After res deasserts: green[0] rises after ALLRED_CYC clocks.
- Output changes appear on the same edge as the state register update; there is no extra pipeline stage.
- ped_req[i] is latched into pending[i] on any clock where it is high.
- At GREEN entry for approach d, if pending[d] is set (or ped_req[d] is high that cycle):
  - ped_ack[d] pulses for that cycle.
  - pending[d] clears.
  - walk[d] is held high for the whole GREEN of d.
- A request for d arriving after GREEN entry stays pending until d's next green.
- Truncation: in GREEN of d, if pending[j] is set for any j != d and the elapsed green count is >= MIN_GREEN, move to YELLOW on the next enabled clock. A pending request only for d itself never truncates.

## Configuration
- Macro TL_PED_EN.
- Defined: pending, walk, ped_ack and green truncation are present as described.
- Undefined: ped_req is ignored, walk and ped_ack are tied 0, and green always lasts GREEN_CYC.

## Structure
- Package tl_pkg: state enum (ALLRED, GREEN, YELLOW), state width constant, and a dir-width function. Elaboration-time parameter range checks live in the top module.
- One sub-module, tl_phase_timer: loadable down-counter with en, CNT_W wide, a zero flag, and an elapsed-count output used for the MIN_GREEN check.

## Test plan
Default configuration for all scenarios: NUM_DIR=2, GREEN_CYC=5, YELLOW_CYC=2, ALLRED_CYC=1, MIN_GREEN=2, TL_PED_EN defined unless stated.
- Reset and free-run, en=1:
  - During reset: red=2'b11, green=0.
  - After release: green=01 for 5 clocks, yellow=01 for 2, red=11 for 1, then green=10; phase_done pulses once per YELLOW exit.
- en gating: drop en for 3 clocks in the middle of green[0] -> green[0] lasts 8 clocks; the timer value is held while en is low.
- Pedestrian truncation: pulse ped_req[1] on the first green[0] clock -> green[0] lasts 2 clocks, then yellow. At green[1] entry, ped_ack[1] pulses once and walk[1] stays high for the full green[1].
- Wrap with NUM_DIR=3: green sequence is dir 0, 1, 2, 0 with no skipped approach and no double green.
- Async reset mid-yellow: drive res low between clock edges -> red=all ones and yellow=0 immediately, without waiting for a clock edge.
- TL_PED_EN undefined: toggle ped_req randomly -> walk=0 and ped_ack=0 throughout, and every green lasts 5 clocks.
